uart_receiver: RTL and testbench
================================

// Module: uart_receiver
// PURPOSE
// Receive side of the UART link; consumes the serial line driven by the transmitter's TxD.
// Frame: 1 start (0), 8 data LSB-first, 1 even-parity bit (= ^data), 1 stop (1).
// Oversamples RxD with an internal 16x tick, majority-votes each bit and presents the byte.
// Flags parity and framing errors to the host logic.
// PARAMETERS
// CLK_FREQ     50_000_000  clk frequency in Hz; tick divisor = round(CLK_FREQ/(16*baud))
// SYNC_STAGES  2           RxD synchroniser depth (>=2)
// PORTS
// clk          in   1  system clock, all logic on posedge
// reset        in   1  reset, asynchronous, active-high
// baud_select  in   3  000..111 = 300,1200,4800,9600,19200,38400,57600,115200 baud
// Rx_EN        in   1  1 = receiver enabled; 0 = held in IDLE
// RxD          in   1  serial input, idle high, asynchronous to clk
// Rx_DATA      out  8  last good byte; updated only on a good frame
// Rx_VALID     out  1  1-clk pulse: good frame, Rx_DATA updated same cycle
// Rx_PERROR    out  1  parity mismatch in last frame; held
// Rx_FERROR    out  1  stop bit sampled 0 in last frame; held
// Rx_BUSY      out  1  1 while in START/DATA/PARITY/STOP
// BEHAVIOUR
// - Reset: Rx_DATA=0, Rx_VALID=0, Rx_PERROR=0, Rx_FERROR=0, Rx_BUSY=0, state IDLE, sync flops=1.
// - Tick gen: 14-bit counter; tick = 1-clk pulse every DIV clk (50 MHz: 10417,2604,651,326,163,81,54,27).
//   Counter restarts at 0 when baud_select changes; counter runs regardless of state.
// - Sample count sc (4 bit, 0..15) advances on each tick; bit index bi (3 bit).
// - All FSM decisions on tick cycles only, using synchronised RxD (rxs).
// - IDLE: tick & rxs==0 -> START, sc=0, clear Rx_PERROR/Rx_FERROR.
// - START: at sc==8 majority(sc 7,8,9 samples) evaluated at sc==9; if 1 -> false start, IDLE.
//   sc==15 -> DATA, bi=0, sc=0.
// - DATA: majority of sc 7,8,9 shifted in at sc==9 (LSB first); sc==15: bi==7 -> PARITY else bi+1.
// - PARITY: majority bit p at sc==9; perr = p ^ (^data); sc==15 -> STOP.
// - STOP: majority bit s at sc==9, then same cycle -> IDLE (no wait for bit end, allows
//   back-to-back frames). s==0 -> Rx_FERROR=1. perr -> Rx_PERROR=1.
//   Both clean -> Rx_DATA=data, Rx_VALID=1 next clk only. Any error: Rx_DATA unchanged, no VALID.
// - Latency: Rx_VALID in the clk after the stop-bit sc==9 tick (~10.6 bit times after start edge).
// - Rx_EN=0: next clk -> IDLE, frame in progress discarded, no flags/VALID; outputs otherwise held.
// - Rx_EN rising mid-line-activity: frame start only on next rxs==0 seen in IDLE.
// - Reset mid-frame: immediate return to reset values; partial frame lost.
// - Break (RxD held 0): one frame with FERROR, then IDLE restarts only after rxs returns to 1
//   (IDLE requires rxs==1 seen at least one tick before accepting a new start).
// - Rx_BUSY=1 from START entry until the STOP->IDLE transition.
// TESTING
// 1 baud_select=111, send 0xA5 parity 0 stop 1 -> Rx_DATA=0xA5, one Rx_VALID pulse, errors 0.
// 2 send 0x3C with parity 1 -> Rx_PERROR=1, no Rx_VALID, Rx_DATA keeps 0xA5; next good frame clears it.
// 3 send 0x55 with stop=0 -> Rx_FERROR=1, no Rx_VALID; RxD high then 0x0F frame -> VALID, FERROR=0.
// 4 RxD low for 5 ticks then high -> false start, Rx_BUSY drops, no VALID/flags.
// 5 Rx_EN=0 during D3 of 0x81 -> no VALID; Rx_EN=1, frame 0x81 -> VALID, Rx_DATA=0x81.
// 6 back-to-back 0x00,0xFF at 011 and 000; reset asserted mid-frame -> all outputs 0, next frame ok.

Source files
------------

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8E1 UART receiver with 16x oversampling and 3-sample majority vote
module uart_receiver #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       Rx_EN,
  input  logic       RxD,
  output logic [7:0] Rx_DATA,
  output logic       Rx_VALID,
  output logic       Rx_PERROR,
  output logic       Rx_FERROR,
  output logic       Rx_BUSY
);

  function automatic logic [13:0] div_of(input int baud);
    return 14'((CLK_FREQ + 8 * baud) / (16 * baud));
  endfunction

  localparam logic [13:0] DIV_300    = div_of(300);
  localparam logic [13:0] DIV_1200   = div_of(1200);
  localparam logic [13:0] DIV_4800   = div_of(4800);
  localparam logic [13:0] DIV_9600   = div_of(9600);
  localparam logic [13:0] DIV_19200  = div_of(19200);
  localparam logic [13:0] DIV_38400  = div_of(38400);
  localparam logic [13:0] DIV_57600  = div_of(57600);
  localparam logic [13:0] DIV_115200 = div_of(115200);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [2:0]             baud_q, baud_d;
  logic [13:0]            cnt_q, cnt_d;
  logic [13:0]            div;
  logic                   tick;
  logic                   rxs;
  logic                   maj;

  state_t      state_q, state_d;
  logic [3:0]  sc_q, sc_d;
  logic [2:0]  bi_q, bi_d;
  logic [1:0]  samp_q, samp_d;   // [1] = sample at sc 7, [0] = sample at sc 8
  logic [7:0]  shift_q, shift_d;
  logic        perr_q, perr_d;
  logic        armed_q, armed_d; // line seen high in IDLE since the last frame/abort
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_perror_q, rx_perror_d;
  logic        rx_ferror_q, rx_ferror_d;

  assign rxs = sync_q[SYNC_STAGES-1];
  assign maj = (samp_q[1] & samp_q[0]) | (samp_q[1] & rxs) | (samp_q[0] & rxs);

  // Synchroniser shift and baud tick generator; counter restarts on a baud change
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], RxD};
    baud_d = baud_select;
    case (baud_select)
      3'd0:    div = DIV_300;
      3'd1:    div = DIV_1200;
      3'd2:    div = DIV_4800;
      3'd3:    div = DIV_9600;
      3'd4:    div = DIV_19200;
      3'd5:    div = DIV_38400;
      3'd6:    div = DIV_57600;
      default: div = DIV_115200;
    endcase
    tick  = (cnt_q == div - 14'd1);
    cnt_d = tick ? 14'd0 : cnt_q + 14'd1;
    if (baud_select != baud_q) cnt_d = 14'd0;
  end

  // Frame FSM: every decision is taken on a tick, using the synchronised line
  always_comb begin
    state_d     = state_q;
    sc_d        = sc_q;
    bi_d        = bi_q;
    samp_d      = samp_q;
    shift_d     = shift_q;
    perr_d      = perr_q;
    armed_d     = armed_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    rx_perror_d = rx_perror_q;
    rx_ferror_d = rx_ferror_q;
    if (!Rx_EN) begin
      state_d = S_IDLE;
      armed_d = 1'b0;
    end else if (tick) begin
      if (state_q != S_IDLE) begin
        sc_d = sc_q + 4'd1;
        if (sc_q == 4'd7) samp_d[1] = rxs;
        if (sc_q == 4'd8) samp_d[0] = rxs;
      end
      case (state_q)
        S_IDLE: begin
          if (armed_q && !rxs) begin
            state_d     = S_START;
            sc_d        = 4'd0;
            armed_d     = 1'b0;
            rx_perror_d = 1'b0;
            rx_ferror_d = 1'b0;
          end else if (rxs) begin
            armed_d = 1'b1;
          end
        end
        S_START: begin
          if (sc_q == 4'd9 && maj) begin
            state_d = S_IDLE;
          end else if (sc_q == 4'd15) begin
            state_d = S_DATA;
            bi_d    = 3'd0;
            sc_d    = 4'd0;
          end
        end
        S_DATA: begin
          if (sc_q == 4'd9) shift_d = {maj, shift_q[7:1]};
          if (sc_q == 4'd15) begin
            if (bi_q == 3'd7) state_d = S_PARITY;
            else              bi_d    = bi_q + 3'd1;
          end
        end
        S_PARITY: begin
          if (sc_q == 4'd9)  perr_d  = maj ^ (^shift_q);
          if (sc_q == 4'd15) state_d = S_STOP;
        end
        S_STOP: begin
          // Leave at mid-stop so a back-to-back start edge is not missed
          if (sc_q == 4'd9) begin
            state_d     = S_IDLE;
            rx_ferror_d = !maj;
            rx_perror_d = perr_q;
            if (maj && !perr_q) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q      <= '1;
      baud_q      <= 3'd0;
      cnt_q       <= 14'd0;
      state_q     <= S_IDLE;
      sc_q        <= 4'd0;
      bi_q        <= 3'd0;
      samp_q      <= 2'b00;
      shift_q     <= 8'd0;
      perr_q      <= 1'b0;
      armed_q     <= 1'b0;
      rx_data_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
      rx_perror_q <= 1'b0;
      rx_ferror_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      baud_q      <= baud_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      sc_q        <= sc_d;
      bi_q        <= bi_d;
      samp_q      <= samp_d;
      shift_q     <= shift_d;
      perr_q      <= perr_d;
      armed_q     <= armed_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_perror_q <= rx_perror_d;
      rx_ferror_q <= rx_ferror_d;
    end
  end

  assign Rx_DATA   = rx_data_q;
  assign Rx_VALID  = rx_valid_q;
  assign Rx_PERROR = rx_perror_q;
  assign Rx_FERROR = rx_ferror_q;
  assign Rx_BUSY   = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - frame-level reference model bench for uart_receiver
module tb_uart_receiver;
  localparam int CLK_FREQ = 1_000_000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] baud_select = 3'd7;
  logic       Rx_EN = 1'b1;
  logic       RxD = 1'b1;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_BUSY;

  uart_receiver #(.CLK_FREQ(CLK_FREQ), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .baud_select(baud_select), .Rx_EN(Rx_EN), .RxD(RxD),
    .Rx_DATA(Rx_DATA), .Rx_VALID(Rx_VALID), .Rx_PERROR(Rx_PERROR),
    .Rx_FERROR(Rx_FERROR), .Rx_BUSY(Rx_BUSY)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         bit_clks = 16;
  logic [7:0] exp_data = 8'd0;
  logic       exp_perr = 1'b0;
  logic       exp_ferr = 1'b0;
  logic       chk_en = 1'b0;
  logic [7:0] vq[$];

  function automatic int bit_period(input logic [2:0] b);
    int baud;
    case (b)
      3'd0: baud = 300;
      3'd1: baud = 1200;
      3'd2: baud = 4800;
      3'd3: baud = 9600;
      3'd4: baud = 19200;
      3'd5: baud = 38400;
      3'd6: baud = 57600;
      default: baud = 115200;
    endcase
    return 16 * ((CLK_FREQ + 8 * baud) / (16 * baud));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Every cycle: each VALID must match a queued good frame; settled outputs must match the model
  always @(negedge clk) begin
    if (!reset) begin
      if (Rx_VALID) begin
        check("valid_pulse", 32'(Rx_VALID), 32'(vq.size() != 0));
        if (vq.size() != 0) check("valid_data", 32'(Rx_DATA), 32'(vq.pop_front()));
      end
      if (chk_en) begin
        check("data", 32'(Rx_DATA), 32'(exp_data));
        check("perr", 32'(Rx_PERROR), 32'(exp_perr));
        check("ferr", 32'(Rx_FERROR), 32'(exp_ferr));
        check("busy", 32'(Rx_BUSY), 32'd0);
      end
    end
  end

  task automatic idle_bits(input int n, input logic chk);
    RxD = 1'b1;
    chk_en = chk;
    repeat (n * bit_clks) @(posedge clk);
    #1;
    chk_en = 1'b0;
  endtask

  task automatic set_baud(input logic [2:0] b);
    baud_select = b;
    bit_clks = bit_period(b);
    idle_bits(1, 1'b0);
  endtask

  // drop_bit >= 0 deasserts Rx_EN halfway through that frame bit until the frame ends
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input int drop_bit, input int gap);
    logic [10:0] bits;
    logic        good;
    bits = {stp, par, d, 1'b0};
    good = (par == ^d) && stp && (drop_bit < 0);
    chk_en = 1'b0;
    if (good) vq.push_back(d);
    for (int i = 0; i < 11; i++) begin
      RxD = bits[i];
      if (i == drop_bit) begin
        repeat (bit_clks / 2) @(posedge clk);
        #1;
        Rx_EN = 1'b0;
        repeat (bit_clks - bit_clks / 2) @(posedge clk);
        #1;
      end else begin
        repeat (bit_clks) @(posedge clk);
        #1;
      end
    end
    RxD = 1'b1;
    Rx_EN = 1'b1;
    check("valid_seen_by_frame_end", 32'(vq.size()), 32'd0);
    if (drop_bit < 0) begin
      exp_perr = (par != ^d);
      exp_ferr = !stp;
      if (good) exp_data = d;
    end
    if (gap > 0) idle_bits(gap, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, 32'(Rx_DATA), 32'd0);
    check({tag, "_valid"}, 32'(Rx_VALID), 32'd0);
    check({tag, "_perr"}, 32'(Rx_PERROR), 32'd0);
    check({tag, "_ferr"}, 32'(Rx_FERROR), 32'd0);
    check({tag, "_busy"}, 32'(Rx_BUSY), 32'd0);
  endtask

  initial begin
    logic [7:0]  rd;
    logic        pe, fe;
    int          gap;
    logic [10:0] part;

    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    bit_clks = bit_period(3'd7);
    idle_bits(2, 1'b1);

    // good frame
    send_frame(8'hA5, 1'b0, 1'b1, -1, 2);
    check("t1_data", 32'(Rx_DATA), 32'hA5);
    check("t1_perr", 32'(Rx_PERROR), 32'd0);

    // parity error keeps old byte, next good frame clears it
    send_frame(8'h3C, 1'b1, 1'b1, -1, 2);
    check("t2_perr", 32'(Rx_PERROR), 32'd1);
    check("t2_data", 32'(Rx_DATA), 32'hA5);
    send_frame(8'h12, 1'b0, 1'b1, -1, 2);
    check("t2_perr_cleared", 32'(Rx_PERROR), 32'd0);
    check("t2_data_next", 32'(Rx_DATA), 32'h12);

    // framing error then recovery
    send_frame(8'h55, 1'b0, 1'b0, -1, 2);
    check("t3_ferr", 32'(Rx_FERROR), 32'd1);
    check("t3_data", 32'(Rx_DATA), 32'h12);
    send_frame(8'h0F, 1'b0, 1'b1, -1, 2);
    check("t3_ferr_cleared", 32'(Rx_FERROR), 32'd0);
    check("t3_data_next", 32'(Rx_DATA), 32'h0F);

    // false start: 5 ticks low
    RxD = 1'b0;
    repeat (5 * (bit_clks / 16)) @(posedge clk);
    #1;
    check("t4_busy_in_start", 32'(Rx_BUSY), 32'd1);
    RxD = 1'b1;
    idle_bits(1, 1'b0);
    idle_bits(1, 1'b1);
    check("t4_busy_dropped", 32'(Rx_BUSY), 32'd0);

    // receiver disabled during D3
    send_frame(8'h81, 1'b0, 1'b1, 4, 2);
    check("t5_data_unchanged", 32'(Rx_DATA), 32'h0F);
    send_frame(8'h81, 1'b0, 1'b1, -1, 2);
    check("t5_data", 32'(Rx_DATA), 32'h81);

    // break: one framing-error frame, no restart while the line stays low
    RxD = 1'b0;
    repeat (20 * bit_clks) @(posedge clk);
    #1;
    check("brk_busy", 32'(Rx_BUSY), 32'd0);
    check("brk_ferr", 32'(Rx_FERROR), 32'd1);
    exp_ferr = 1'b1;
    exp_perr = 1'b0;
    idle_bits(2, 1'b1);
    send_frame(8'h6B, ^8'h6B, 1'b1, -1, 2);
    check("brk_recover_data", 32'(Rx_DATA), 32'h6B);

    // randomized frames at the faster rates with injected errors
    for (int k = 0; k < 20; k++) begin
      if ($urandom_range(0, 3) == 0) set_baud(3'($urandom_range(4, 7)));
      rd  = 8'($urandom);
      pe  = ($urandom_range(0, 3) == 0);
      fe  = ($urandom_range(0, 3) == 0);
      gap = fe ? $urandom_range(1, 2) : $urandom_range(0, 2);
      send_frame(rd, (^rd) ^ pe, !fe, -1, gap);
    end
    idle_bits(1, 1'b1);

    // back-to-back frames at 9600
    set_baud(3'd3);
    send_frame(8'h00, 1'b0, 1'b1, -1, 0);
    send_frame(8'hFF, 1'b0, 1'b1, -1, 2);
    check("b2b_data", 32'(Rx_DATA), 32'hFF);

    // reset in the middle of a frame
    part = {1'b1, 1'b0, 8'hC3, 1'b0};
    for (int i = 0; i < 5; i++) begin
      RxD = part[i];
      repeat (bit_clks) @(posedge clk);
      #1;
    end
    check("rst_busy_before", 32'(Rx_BUSY), 32'd1);
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    RxD = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_data = 8'd0;
    exp_perr = 1'b0;
    exp_ferr = 1'b0;
    vq.delete();
    idle_bits(2, 1'b1);
    send_frame(8'hC3, 1'b0, 1'b1, -1, 1);
    check("rst_next_data", 32'(Rx_DATA), 32'hC3);

    // slowest rate
    set_baud(3'd0);
    send_frame(8'h5A, 1'b0, 1'b1, -1, 1);
    check("slow_data", 32'(Rx_DATA), 32'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
